tqvp_hx2003_pulse_receiver: RTL
===============================

# tqvp_hx2003_pulse_receiver

Pulse-width receiver that decodes a two-level waveform into the 2-bit symbol encoding consumed by the pulse transmitter: `{level, long}`. Symbol 0 is low/short, 1 is low/long, 2 is high/short and 3 is high/long. It sits directly downstream of the transmitter's output pin, either as a loopback checker or on a PMOD input. Symbols are packed LSB-first, 16 per 32-bit word, in the same layout as the transmitter's data memory. Completed words are buffered in a small show-ahead FIFO for the TinyQV register wrapper to read.

## Interface
- `FIFO_DEPTH`, 4: number of 32-bit word entries; must be a power of 2 and at least 2.
- `clk` in 1: project clock (64 MHz). Synchronous reset; one clock domain.
- `rst` in 1: reset, active-high. Sampled on `clk` rising edge.
- `en` in 1: receiver enable. While low, all state is held cleared, as in reset.
- `sig_in` in 1: waveform input, already synchronized to `clk`.
- `invert` in 1: when high, `sig_in` is inverted before any processing.
- `prescaler` in 4: one duration tick every 2^`prescaler` clocks.
- `threshold_low` in 8: low segment with duration < threshold gives symbol 0; otherwise symbol 1.
- `threshold_high` in 8: high segment with duration < threshold gives symbol 2; otherwise symbol 3.
- `timeout` in 8: idle duration that ends a frame. A value of 0 disables the timeout.
- `rd_en` in 1: pop the FIFO head. Ignored when `rd_valid` is 0.
- `rd_data` out 32: FIFO head word. Reads 0 when empty.
- `rd_valid` out 1: FIFO not empty.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `frame_symbols` out 7: symbols decoded in the current or last frame; saturates at 127.
- `overflow` out 1: sticky. Set when a word is dropped because the FIFO is full.

## Operation
- Input path: level = `sig_in ^ invert`, optionally filtered (see Configuration). An edge is a filtered level that differs from the registered previous level.
- On `en` rising, the previous-level register loads the current level, so no edge is detected in that cycle.
- The FSM has two states, IDLE and MEASURE.
- **IDLE**
  - The first edge enters MEASURE.
  - It clears `frame_symbols`, the packing register and the fill count.
  - The segment before that edge is never emitted.
- **Duration measurement**
  - The prescaler counter and duration counter restart on every edge.
  - Measured duration = floor(L / 2^`prescaler`), saturating at 255, where L is the number of clocks the level was held.
- **MEASURE, on each edge**
  - The completed segment's symbol = {previous level, duration >= threshold for that level}.
  - Symbol k (0..15) of the word is written to bits [2k+1:2k].
  - The fill count is incremented and `frame_symbols` is incremented (saturating).
  - When fill reaches 16, the complete word is pushed and fill returns to 0.
- **MEASURE, on timeout**
  - Timeout occurs when `timeout` != 0 and the current segment's duration reaches `timeout`.
  - The timed-out segment is not emitted.
  - If fill > 0, the partial word is pushed with its unused upper bits set to 0.
  - `frame_done` pulses and the FSM returns to IDLE.
- **FIFO**
  - Push when full: the word is dropped, `overflow` is set and the contents are unchanged.
  - Push and pop in the same cycle while full: the pop is applied, then the push is accepted.
  - Pop and push in the same cycle while empty: the push is accepted and the pop is ignored.
- **`prescaler` changes** mid-frame take effect at the next edge.

## Timing
- **Reset values:** `rd_data`=0, `rd_valid`=0, `frame_done`=0, `frame_symbols`=0, `overflow`=0; FSM in IDLE; FIFO empty.
- **Reset or `en` low mid-frame:** the partial word is discarded, FIFO contents are lost and no `frame_done` is produced.
- **Edge to symbol:** the edge is detected in cycle N. The symbol is registered at the end of cycle N, and `frame_symbols` updates in N+1.
- **16th symbol to FIFO:** the word is pushed at the end of cycle N, so `rd_valid`/`rd_data` update in N+1.
- **Timeout:** the condition is true in cycle T. The flush push completes at the end of T, and `frame_done` is high for exactly cycle T+1.
- **Pop:** `rd_en` in cycle R with `rd_valid`=1 means `rd_data` shows the next entry, or 0, in R+1.
- **Edge and timeout in the same cycle:** the edge wins, the symbol is emitted and the frame continues.

## Configuration
- `PULSE_RECEIVER_GLITCH_FILTER_EN`
  - Defined: a level change is accepted only after the inverted input is stable for 3 consecutive clocks. This adds 2 clocks of latency to every edge; 1- and 2-clock pulses are ignored.
  - Undefined: the inverted input is used directly as the level, with no extra latency.

## Test plan
- **Basic frame decode:** `prescaler`=0, thresholds=10, `timeout`=50, idle low. Drive high 5, low 20, high 20, low 5, high 12, then low for 60 clocks. Required: one word `0x00000336`, `frame_symbols`=5, and a single `frame_done` pulse 50 clocks after the last falling edge.
- **Full-word push:** drive 17 edges alternating high 3 / low 3 clocks, thresholds=10. Required: `rd_data`=`0x22222222` with `rd_valid` rising the cycle after the 17th edge. Timeout then pulses `frame_done` with no second push.
- **FIFO overflow:** with `FIFO_DEPTH`=4 and `rd_en` held low, produce 5 full words. Required: `overflow`=1, and pops return the first 4 words in order, then `rd_valid`=0.
- **Prescaler boundary:** `prescaler`=2, `threshold_high`=4. A high segment of 15 clocks must decode to symbol 2; a high segment of 16 clocks must decode to symbol 3.
- **Reset mid-frame:** assert `rst` for 1 cycle after 7 symbols. Required: `rd_valid`=0, `frame_symbols`=0, no `frame_done`, `overflow`=0.
- **Glitch filter:** insert a 1-clock high glitch in the low idle level. With `PULSE_RECEIVER_GLITCH_FILTER_EN` defined, no frame starts. Undefined, the FSM enters MEASURE and `frame_symbols` increments on the falling edge.

Source files
------------

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// ---------------------------------------------------------------------------
// tqvp_hx2003_pulse_receiver
//
// Pulse-width receiver. It measures how long each level of a two-level
// waveform is held. Each completed segment is decoded into a 2-bit symbol
// {level, long}, and 16 symbols are packed LSB-first into a 32-bit word.
// Completed words go into a small show-ahead FIFO.
//
// A frame starts on the first edge seen while idle. It ends when a segment
// stays idle for `timeout` duration ticks. At that point any partial word is
// flushed and frame_done pulses.
//
// Optional build macro:
//   PULSE_RECEIVER_GLITCH_FILTER_EN - a level change is accepted only after
//   the (inverted) input has been stable for 3 clocks. This adds 2 clocks of
//   edge latency.
//
// Parameters:
//   FIFO_DEPTH      number of 32-bit FIFO entries (power of 2, >= 2)
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              enable; while low all state is held cleared
//   sig_in          synchronized waveform input
//   invert          invert sig_in before processing
//   prescaler       one duration tick every 2^prescaler clocks
//   threshold_low   low segments at/above this duration are "long"
//   threshold_high  high segments at/above this duration are "long"
//   timeout         idle duration that ends a frame (0 = never)
//   rd_en           pop FIFO head
//   rd_data         FIFO head word (0 when empty)
//   rd_valid        FIFO not empty
//   frame_done      one-cycle pulse at end of frame
//   frame_symbols   symbols in current/last frame, saturating at 127
//   overflow        sticky: a word was dropped on a full FIFO
// ---------------------------------------------------------------------------
module tqvp_hx2003_pulse_receiver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sig_in,
    input  logic        invert,
    input  logic [3:0]  prescaler,
    input  logic [7:0]  threshold_low,
    input  logic [7:0]  threshold_high,
    input  logic [7:0]  timeout,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        frame_done,
    output logic [6:0]  frame_symbols,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_MEASURE} state_t;

    logic        w_clear;
    logic        w_raw;
    logic        w_level;
    logic        r_en_d;
    logic        r_prev_level;
    logic        w_edge;
    logic        w_restart;

    assign w_clear = rst | ~en;
    assign w_raw   = sig_in ^ invert;

    // ---------------- input conditioning ----------------
`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;

    // The level follows the input only when this sample and the two before
    // it agree. Otherwise the last accepted level is held.
    assign w_level = (w_raw == r_hist[0] && w_raw == r_hist[1]) ? w_raw : r_filt;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_hist <= 2'b00;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], w_raw};
            r_filt <= w_level;
        end
    end
`else
    assign w_level = w_raw;
`endif

    // r_en_d is low in the first enabled cycle. That cycle only loads the
    // previous-level register, so no spurious edge is seen on enable.
    assign w_edge    = r_en_d & (w_level != r_prev_level);
    assign w_restart = w_edge | ~r_en_d;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_en_d       <= 1'b0;
            r_prev_level <= 1'b0;
        end else begin
            r_en_d       <= 1'b1;
            r_prev_level <= w_level;
        end
    end

    // ---------------- duration measurement ----------------
    // r_dur holds floor(clocks_held / 2^prescaler). The count includes the
    // edge cycle and excludes the current cycle. The prescaler is latched
    // at each edge, so mid-segment changes wait for the next edge.
    logic [14:0] r_pre_cnt;
    logic [7:0]  r_dur;
    logic [3:0]  r_presc;
    logic [3:0]  w_presc;
    logic [15:0] w_pre_inc;
    logic [7:0]  w_dur_base;
    logic        w_dur_tick;

    assign w_presc    = w_restart ? prescaler : r_presc;
    assign w_pre_inc  = {1'b0, (w_restart ? 15'd0 : r_pre_cnt)} + 16'd1;
    assign w_dur_base = w_restart ? 8'd0 : r_dur;
    assign w_dur_tick = (w_pre_inc == (16'd1 << w_presc));

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_pre_cnt <= '0;
            r_dur     <= '0;
            r_presc   <= '0;
        end else begin
            r_presc <= w_presc;
            if (w_dur_tick) begin
                r_pre_cnt <= '0;
                r_dur     <= (w_dur_base == 8'hFF) ? 8'hFF : w_dur_base + 8'd1;
            end else begin
                r_pre_cnt <= w_pre_inc[14:0];
                r_dur     <= w_dur_base;
            end
        end
    end

    // ---------------- frame FSM ----------------
    state_t r_state;
    state_t w_state_next;
    logic   w_start;
    logic   w_emit;
    logic   w_flush;
    logic   w_timeout_hit;

    assign w_timeout_hit = (timeout != 8'd0) && (r_dur >= timeout);

    always_ff @(posedge clk) begin
        if (w_clear) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_emit       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_start      = 1'b1;
                    w_state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                // An edge takes priority over a timeout in the same cycle.
                if (w_edge) begin
                    w_emit = 1'b1;
                end else if (w_timeout_hit) begin
                    w_flush      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- symbol packing ----------------
    logic [31:0] r_pack;
    logic [3:0]  r_fill;
    logic [6:0]  r_syms;
    logic        r_frame_done;
    logic [1:0]  w_sym;
    logic [31:0] w_pack_ins;
    logic        w_push;
    logic [31:0] w_push_data;

    assign w_sym = {r_prev_level, (r_dur >= (r_prev_level ? threshold_high : threshold_low))};

    // Pack the new symbol into slot r_fill. The other slots keep their values.
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
        assign w_pack_ins[2*gi+1:2*gi] = (r_fill == 4'(gi)) ? w_sym : r_pack[2*gi+1:2*gi];
    end

    assign w_push      = (w_emit && r_fill == 4'd15) || (w_flush && r_fill != 4'd0);
    assign w_push_data = w_flush ? r_pack : w_pack_ins;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_pack       <= '0;
            r_fill       <= '0;
            r_syms       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_flush;
            if (w_start) begin
                r_pack <= '0;
                r_fill <= '0;
                r_syms <= '0;
            end else if (w_emit) begin
                r_syms <= (r_syms == 7'd127) ? r_syms : r_syms + 7'd1;
                if (r_fill == 4'd15) begin
                    r_pack <= '0;
                    r_fill <= '0;
                end else begin
                    r_pack <= w_pack_ins;
                    r_fill <= r_fill + 4'd1;
                end
            end else if (w_flush) begin
                r_pack <= '0;
                r_fill <= '0;
            end
        end
    end

    // ---------------- show-ahead FIFO ----------------
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_pop;
    logic          w_room;
    logic          w_do_push;

    // A pop in the same cycle frees a slot for a push to a full FIFO.
    assign w_pop     = rd_en && (r_count != '0);
    assign w_room    = (r_count != (AW+1)'(FIFO_DEPTH)) || w_pop;
    assign w_do_push = w_push && w_room && !w_clear;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_pop) r_count <= r_count - 1'b1;
            if (w_push && !w_room) r_overflow <= 1'b1;
        end
    end

    assign rd_valid      = (r_count != '0);
    assign rd_data       = rd_valid ? r_mem[r_rd_ptr] : 32'd0;
    assign frame_done    = r_frame_done;
    assign frame_symbols = r_syms;
    assign overflow      = r_overflow;

endmodule
